selecting_ctrl: RTL and testbench

- Main selection state machine; takes over the 8x8 lattice and 8-digit display once the power-on blink test reports done.
- Debounces three raw push-buttons, lets the user step through NUM_ITEMS candidates, confirm one and lock the result.
- Drives the display on/off control consumed by the lattice and segment decoders, and the selected index for the digit decoder.
- Single clock domain; every timebase is a counter on clk, with no derived clocks.

---
 rtl/selecting_ctrl.sv | 174 +++++++++++++++++
 tb/tb_selecting_ctrl.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/selecting_ctrl.sv
// Selection controller: debounces three buttons, steps through NUM_ITEMS candidates,
// blinks the display while confirming and locks the chosen index until reset.
//
// state      | meaning
// -----------+---------------------------------------------------------------
// ST_WAIT    | display dark, waiting for the power-on display test to finish
// ST_BROWSE  | display lit, next steps sel_idx, ok enters confirm
// ST_CONFIRM | display blinks, ok locks the selection, back returns to browse
// ST_LOCKED  | display lit, confirm_idx held, only reset leaves
module selecting_ctrl #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int BLINK_HALF      = 12500000,
    parameter int NUM_ITEMS       = 6
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       startup_done,
    input  logic       key_next,
    input  logic       key_ok,
    input  logic       key_back,
    output logic [2:0] sel_idx,
    output logic       disp_on,
    output logic [1:0] state,
    output logic       confirm_valid,
    output logic [2:0] confirm_idx
);

    localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam int BL_W = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [DB_W-1:0] DB_MAX    = DB_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [BL_W-1:0] BL_MAX    = BL_W'(BLINK_HALF - 1);
    localparam logic [2:0]      LAST_ITEM = 3'(NUM_ITEMS - 1);

    typedef enum logic [1:0] {
        ST_WAIT    = 2'd0,
        ST_BROWSE  = 2'd1,
        ST_CONFIRM = 2'd2,
        ST_LOCKED  = 2'd3
    } state_t;

    // Key lanes: bit 0 = next, bit 1 = ok, bit 2 = back.
    logic [2:0]      raw_keys;
    logic [2:0]      sync1_q;
    logic [2:0]      sync2_q;
    logic [2:0]      deb_q;
    logic [2:0]      press_q;
    logic [DB_W-1:0] db_cnt_q [3];

    assign raw_keys = {key_back, key_ok, key_next};

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            deb_q   <= '0;
            press_q <= '0;
            for (int k = 0; k < 3; k++) begin
                db_cnt_q[k] <= '0;
            end
        end else begin
            sync1_q <= raw_keys;
            sync2_q <= sync1_q;
            for (int k = 0; k < 3; k++) begin
                press_q[k] <= 1'b0;
                if (sync2_q[k] == deb_q[k]) begin
                    db_cnt_q[k] <= '0;
                end else if (db_cnt_q[k] == DB_MAX) begin
                    // Only a debounced rising level counts as a press.
                    db_cnt_q[k] <= '0;
                    deb_q[k]    <= sync2_q[k];
                    press_q[k]  <= sync2_q[k];
                end else begin
                    db_cnt_q[k] <= db_cnt_q[k] + DB_W'(1);
                end
            end
        end
    end

    logic ev_ok;
    logic ev_back;
    logic ev_next;

    assign ev_ok   = press_q[1];
    assign ev_back = press_q[2] & ~press_q[1];
    assign ev_next = press_q[0] & ~press_q[1] & ~press_q[2];

    state_t          state_q;
    state_t          state_n;
    logic [2:0]      sel_q;
    logic [2:0]      sel_n;
    logic [2:0]      cidx_q;
    logic [2:0]      cidx_n;
    logic            disp_q;
    logic            disp_n;
    logic            cv_q;
    logic            cv_n;
    logic [BL_W-1:0] blink_q;
    logic [BL_W-1:0] blink_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_WAIT;
            sel_q   <= '0;
            cidx_q  <= '0;
            disp_q  <= 1'b0;
            cv_q    <= 1'b0;
            blink_q <= '0;
        end else begin
            state_q <= state_n;
            sel_q   <= sel_n;
            cidx_q  <= cidx_n;
            disp_q  <= disp_n;
            cv_q    <= cv_n;
            blink_q <= blink_n;
        end
    end

    always_comb begin
        state_n = state_q;
        sel_n   = sel_q;
        cidx_n  = cidx_q;
        disp_n  = disp_q;
        cv_n    = 1'b0;
        blink_n = blink_q;
        case (state_q)
            ST_WAIT: begin
                disp_n = 1'b0;
                if (startup_done) begin
                    state_n = ST_BROWSE;
                    disp_n  = 1'b1;
                end
            end
            ST_BROWSE: begin
                disp_n = 1'b1;
                if (ev_ok) begin
                    state_n = ST_CONFIRM;
                    blink_n = '0;
                end else if (ev_next) begin
                    sel_n = (sel_q == LAST_ITEM) ? 3'd0 : sel_q + 3'd1;
                end
            end
            ST_CONFIRM: begin
                if (ev_ok) begin
                    state_n = ST_LOCKED;
                    cv_n    = 1'b1;
                    cidx_n  = sel_q;
                    disp_n  = 1'b1;
                end else if (ev_back) begin
                    state_n = ST_BROWSE;
                    disp_n  = 1'b1;
                end else if (blink_q == BL_MAX) begin
                    blink_n = '0;
                    disp_n  = ~disp_q;
                end else begin
                    blink_n = blink_q + BL_W'(1);
                end
            end
            ST_LOCKED: begin
                disp_n = 1'b1;
                sel_n  = cidx_q;
            end
            default: begin
                state_n = ST_WAIT;
            end
        endcase
    end

    assign sel_idx       = sel_q;
    assign disp_on       = disp_q;
    assign state         = state_q;
    assign confirm_valid = cv_q;
    assign confirm_idx   = cidx_q;

endmodule

// File: tb/tb_selecting_ctrl.sv
// Bench for selecting_ctrl: a window-based key model and a rule-level selection model
// are compared against the DUT after every clock edge, plus hand-computed spot checks.
module tb_selecting_ctrl;

    localparam int DB = 4;
    localparam int BH = 8;
    localparam int NI = 6;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       startup_done = 1'b0;
    logic       key_next = 1'b0;
    logic       key_ok = 1'b0;
    logic       key_back = 1'b0;
    logic [2:0] sel_idx;
    logic       disp_on;
    logic [1:0] state;
    logic       confirm_valid;
    logic [2:0] confirm_idx;

    int n_cmp = 0;
    int n_bad = 0;

    selecting_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .BLINK_HALF     (BH),
        .NUM_ITEMS      (NI)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .startup_done (startup_done),
        .key_next     (key_next),
        .key_ok       (key_ok),
        .key_back     (key_back),
        .sel_idx      (sel_idx),
        .disp_on      (disp_on),
        .state        (state),
        .confirm_valid(confirm_valid),
        .confirm_idx  (confirm_idx)
    );

    always #5 clk = ~clk;

    // Model: a key is accepted once the last DB synchronised samples (raw values from
    // 2..DB+1 edges ago) all disagree with the accepted level; the press acts one edge later.
    int          m_state = 0;
    int          m_sel = 0;
    int          m_cidx = 0;
    int          m_since = 0;
    bit          m_disp = 1'b0;
    bit          m_cv = 1'b0;
    bit [2:0]    m_deb = '0;
    bit [2:0]    m_prs = '0;
    bit [DB+1:0] hist [3];
    bit          eo;
    bit          eb;
    bit          en;
    bit          flip;
    bit [2:0]    raw;

    always @(posedge clk) begin
        if (rst) begin
            m_state = 0;
            m_sel   = 0;
            m_cidx  = 0;
            m_since = 0;
            m_disp  = 1'b0;
            m_cv    = 1'b0;
            m_deb   = '0;
            m_prs   = '0;
            for (int k = 0; k < 3; k++) hist[k] = '0;
        end else begin
            eo = m_prs[1];
            eb = m_prs[2] && !eo;
            en = m_prs[0] && !eo && !eb;
            m_cv = 1'b0;
            case (m_state)
                0: if (startup_done) m_state = 1;
                1: begin
                    if (eo) begin
                        m_state = 2;
                        m_since = 0;
                    end else if (en) begin
                        m_sel = (m_sel + 1) % NI;
                    end
                end
                2: begin
                    if (eo) begin
                        m_state = 3;
                        m_cv    = 1'b1;
                        m_cidx  = m_sel;
                    end else if (eb) begin
                        m_state = 1;
                    end else begin
                        m_since++;
                    end
                end
                default: ;
            endcase
            if (m_state == 0) m_disp = 1'b0;
            else if (m_state == 2) m_disp = ((m_since / BH) % 2) == 0;
            else m_disp = 1'b1;

            raw = {key_back, key_ok, key_next};
            for (int k = 0; k < 3; k++) begin
                hist[k] = {hist[k][DB:0], raw[k]};
                flip = 1'b1;
                for (int i = 2; i <= DB + 1; i++) begin
                    if (hist[k][i] == m_deb[k]) flip = 1'b0;
                end
                m_prs[k] = flip && !m_deb[k];
                if (flip) m_deb[k] = !m_deb[k];
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("state", int'(state), m_state);
        chk("sel_idx", int'(sel_idx), m_sel);
        chk("disp_on", int'(disp_on), int'(m_disp));
        chk("confirm_valid", int'(confirm_valid), int'(m_cv));
        chk("confirm_idx", int'(confirm_idx), m_cidx);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
            compare_all();
        end
    endtask

    task automatic set_key(input int k, input logic v);
        case (k)
            0: key_next = v;
            1: key_ok = v;
            default: key_back = v;
        endcase
    endtask

    task automatic press(input int k);
        set_key(k, 1'b1);
        step(8);
        set_key(k, 1'b0);
        step(8);
    endtask

    initial begin
        step(3);
        rst = 1'b0;
        chk("lit_reset_state", int'(state), 0);
        chk("lit_reset_disp", int'(disp_on), 0);

        // Keys are ignored before the display test completes.
        key_next = 1'b1; key_ok = 1'b1; key_back = 1'b1;
        step(8);
        key_next = 1'b0; key_ok = 1'b0; key_back = 1'b0;
        step(8);
        chk("lit_wait_state", int'(state), 0);
        chk("lit_wait_sel", int'(sel_idx), 0);

        startup_done = 1'b1;
        step(1);
        chk("lit_browse_state", int'(state), 1);
        chk("lit_browse_disp", int'(disp_on), 1);

        // Press latency: DB+3 edges from the first sampling edge.
        key_next = 1'b1;
        step(6);
        chk("lit_latency_before", int'(sel_idx), 0);
        step(1);
        chk("lit_latency_at", int'(sel_idx), 1);
        step(5);
        chk("lit_held_once", int'(sel_idx), 1);
        key_next = 1'b0;
        step(8);
        for (int p = 2; p <= 6; p++) begin
            press(0);
            chk("lit_next_seq", int'(sel_idx), p % NI);
        end

        key_next = 1'b1;
        step(2);
        key_next = 1'b0;
        step(10);
        chk("lit_glitch_sel", int'(sel_idx), 0);
        chk("lit_glitch_state", int'(state), 1);

        for (int p = 0; p < 3; p++) press(0);
        chk("lit_sel3", int'(sel_idx), 3);

        key_ok = 1'b1;
        step(7);
        chk("lit_confirm_entry", int'(state), 2);
        chk("lit_blink_0", int'(disp_on), 1);
        key_ok = 1'b0;
        step(7);
        chk("lit_blink_7", int'(disp_on), 1);
        step(1);
        chk("lit_blink_8", int'(disp_on), 0);
        step(7);
        chk("lit_blink_15", int'(disp_on), 0);
        step(1);
        chk("lit_blink_16", int'(disp_on), 1);
        step(7);
        chk("lit_blink_23", int'(disp_on), 1);

        press(2);
        chk("lit_back_state", int'(state), 1);
        chk("lit_back_sel", int'(sel_idx), 3);
        chk("lit_back_disp", int'(disp_on), 1);

        press(1);
        key_ok = 1'b1;
        step(6);
        chk("lit_pre_lock_state", int'(state), 2);
        chk("lit_pre_lock_cv", int'(confirm_valid), 0);
        step(1);
        chk("lit_lock_state", int'(state), 3);
        chk("lit_lock_cv", int'(confirm_valid), 1);
        chk("lit_lock_idx", int'(confirm_idx), 3);
        step(1);
        chk("lit_lock_cv_end", int'(confirm_valid), 0);
        key_ok = 1'b0;
        step(8);
        press(0);
        press(2);
        press(1);
        chk("lit_locked_state", int'(state), 3);
        chk("lit_locked_sel", int'(sel_idx), 3);
        chk("lit_locked_idx", int'(confirm_idx), 3);

        // Key held through reset release yields a single press.
        key_next = 1'b1;
        rst = 1'b1;
        step(2);
        rst = 1'b0;
        step(6);
        chk("lit_held_rst_before", int'(sel_idx), 0);
        step(1);
        chk("lit_held_rst_at", int'(sel_idx), 1);
        step(8);
        chk("lit_held_rst_once", int'(sel_idx), 1);
        key_next = 1'b0;
        step(8);
        press(0);

        key_ok = 1'b1; key_next = 1'b1;
        step(8);
        chk("lit_simul_state", int'(state), 2);
        chk("lit_simul_sel", int'(sel_idx), 2);
        key_ok = 1'b0; key_next = 1'b0;
        step(4);

        rst = 1'b1;
        step(1);
        chk("lit_rst_state", int'(state), 0);
        chk("lit_rst_sel", int'(sel_idx), 0);
        chk("lit_rst_disp", int'(disp_on), 0);
        chk("lit_rst_cv", int'(confirm_valid), 0);
        chk("lit_rst_idx", int'(confirm_idx), 0);
        rst = 1'b0;
        step(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
